// File: rtl/gps_pkg.sv
// Shared GPSDO constants, loop-filter widths, FSM state types and a DAC clamp helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gps_pkg;

   // DIFF code meaning zero frequency error, and the tuning word after reset
   localparam int CENTER   = 32767;
   localparam int DAC_INIT = 32768;

   // Loop filter gains, serial clock divider and lock window
   localparam int KP_SHIFT = 2;
   localparam int KI_SHIFT = 6;
   localparam int SCLK_DIV = 4;
   localparam int LOCK_TOL = 8;
   localparam int LOCK_CNT = 16;

   // Datapath widths
   localparam int DAC_W     = 16;
   localparam int ERR_W     = 17;
   localparam int INTEG_W   = 24;
   localparam int SUM_W     = 26;
   localparam int INTEG_MAX = (1 << (INTEG_W - 1)) - 1;

   localparam logic signed [SUM_W-1:0] DAC_MAX_S = SUM_W'(65535);

   // Loop-filter sequencer: LOAD hands the new word to the serialiser, XFER waits for its tail
   typedef enum logic [1:0] {LS_IDLE, LS_CALC, LS_LOAD, LS_XFER} loop_state_t;

   // Serialiser phases of one DAC frame
   typedef enum logic [1:0] {SS_IDLE, SS_LOAD, SS_SHIFT, SS_TAIL} spi_state_t;

   // Clamp the signed filter sum into the unsigned DAC code range
   function automatic logic [DAC_W-1:0] clamp_dac(input logic signed [SUM_W-1:0] v);
      if (v[SUM_W-1])
         return '0;
      else if (v > DAC_MAX_S)
         return '1;
      else
         return v[DAC_W-1:0];
   endfunction

endpackage

// File: rtl/ocxo_tune_ctrl_if.sv
// Sample input and DAC/status outputs of the OCXO tuning controller, grouped as one bundle.
// Latency: none (wiring only).
// Backpressure: none; samples arriving while busy are held in a one-deep newest-wins slot.
interface ocxo_tune_ctrl_if;
   logic [15:0] DIFF;
   logic        RDY;
   logic        HOLD;
   logic [15:0] TUNE;
   logic        BUSY;
   logic        SAT;
   logic        SCLK;
   logic        SYNC_N;
   logic        SDO;
   logic        LOCKED;

   // Sample producer side (PPS counter)
   modport master (
      output DIFF, RDY, HOLD,
      input  TUNE, BUSY, SAT, SCLK, SYNC_N, SDO, LOCKED
   );

   // Tuning controller side
   modport slave (
      input  DIFF, RDY, HOLD,
      output TUNE, BUSY, SAT, SCLK, SYNC_N, SDO, LOCKED
   );
endinterface

// File: rtl/ocxo_tune_ctrl_dac_spi_tx.sv
// 3-wire DAC serialiser: SYNC_N framing, SCLK divider and a 16-bit MSB-first shifter.
// Latency: SYNC_N low one cycle after start; frame is 1 + 32*SCLK_DIV + SCLK_DIV cycles.
// Backpressure: start is taken only while busy is low; done pulses in the last tail cycle.
module dac_spi_tx
   import gps_pkg::*;
#(
   parameter int SCLK_DIV_P = SCLK_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DAC_W-1:0] word,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             sync_n,
   output logic             sdo
);

   localparam int            CW       = (SCLK_DIV_P > 1) ? $clog2(SCLK_DIV_P) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV_P - 1);

   spi_state_t       state, state_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [3:0]       bitn, bitn_d;
   logic [DAC_W-1:0] sh, sh_d;
   logic             sclk_d, sync_d, sdo_d;

   assign busy = (state != SS_IDLE);

   // Next-state and next-pin logic; pins are registered so they never glitch
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      bitn_d  = bitn;
      sh_d    = sh;
      sclk_d  = sclk;
      sync_d  = sync_n;
      sdo_d   = sdo;
      done    = 1'b0;
      case (state)
         SS_IDLE: begin
            if (start) begin
               state_d = SS_LOAD;
               sh_d    = word;
               sdo_d   = word[DAC_W-1];
               sync_d  = 1'b0;
               cnt_d   = '0;
               bitn_d  = 4'd15;
            end
         end
         SS_LOAD: begin
            state_d = SS_SHIFT;
            cnt_d   = '0;
         end
         SS_SHIFT: begin
            if (cnt == CNT_LAST) begin
               cnt_d = '0;
               if (!sclk) begin
                  sclk_d = 1'b1;
               end else begin
                  // SDO only moves on the falling edge so the DAC sees it stable at the rise
                  sclk_d = 1'b0;
                  if (bitn == 4'd0) begin
                     state_d = SS_TAIL;
                     sync_d  = 1'b1;
                     sdo_d   = 1'b0;
                  end else begin
                     bitn_d = bitn - 1'b1;
                     sh_d   = {sh[DAC_W-2:0], 1'b0};
                     sdo_d  = sh[DAC_W-2];
                  end
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         SS_TAIL: begin
            if (cnt == CNT_LAST) begin
               done    = 1'b1;
               state_d = SS_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
      endcase
   end

   // State, shifter and pin registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SS_IDLE;
         cnt    <= '0;
         bitn   <= '0;
         sh     <= '0;
         sclk   <= 1'b0;
         sync_n <= 1'b1;
         sdo    <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         bitn   <= bitn_d;
         sh     <= sh_d;
         sclk   <= sclk_d;
         sync_n <= sync_d;
         sdo    <= sdo_d;
      end
   end

endmodule

// File: rtl/ocxo_tune_ctrl.sv
// GPSDO loop closure: PI filter on offset-binary DIFF samples, result sent to the OCXO DAC.
// Latency: RDY rise at edge N -> TUNE at N+1 -> SYNC_N low at N+2. Optional TUNE_LOCK_DET_EN adds LOCKED.
// Backpressure: samples during a frame land in a one-deep newest-wins slot; HOLD drops them.
module ocxo_tune_ctrl
   import gps_pkg::*;
(
   input  logic              CLK,
   input  logic              CLR,
   ocxo_tune_ctrl_if.slave   bus
);

   localparam logic signed [INTEG_W:0] ISUM_HI = (INTEG_W + 1)'(INTEG_MAX);
   localparam logic signed [INTEG_W:0] ISUM_LO = -ISUM_HI;

   loop_state_t               lstate, lstate_d;
   logic                      rdy_q, init_req, pending;
   logic [DAC_W-1:0]          samp, tune;
   logic signed [INTEG_W-1:0] integ, integ_new;
   logic                      sat, integ_clamp;
   logic                      ev_acc, go_calc;
   logic                      spi_start, spi_busy, spi_done;
   logic signed [ERR_W-1:0]   err, p_term;
   logic signed [INTEG_W:0]   isum;
   logic signed [INTEG_W-1:0] i_term;
   logic signed [SUM_W-1:0]   p_ext, i_ext, tsum;

   // A sample is a RDY rising edge; HOLD makes the block deaf to it
   assign ev_acc  = bus.RDY && !rdy_q && !bus.HOLD;
   assign go_calc = (lstate_d == LS_CALC);

   // Error is taken from the captured sample so a pending sample survives the frame
   assign err    = $signed({1'b0, samp}) - $signed(ERR_W'(CENTER));
   assign isum   = $signed({integ[INTEG_W-1], integ})
                 + $signed({{(INTEG_W + 1 - ERR_W){err[ERR_W-1]}}, err});
   assign p_term = err >>> KP_SHIFT;
   assign i_term = integ_new >>> KI_SHIFT;
   assign p_ext  = {{(SUM_W - ERR_W){p_term[ERR_W-1]}}, p_term};
   assign i_ext  = {{(SUM_W - INTEG_W){i_term[INTEG_W-1]}}, i_term};
   // Positive error means the oscillator runs fast, so both terms pull the word down
   assign tsum   = $signed(SUM_W'(DAC_INIT)) - p_ext - i_ext;

   // Saturating integrator update
   always_comb begin
      integ_new   = isum[INTEG_W-1:0];
      integ_clamp = 1'b0;
      if (isum > ISUM_HI) begin
         integ_new   = ISUM_HI[INTEG_W-1:0];
         integ_clamp = 1'b1;
      end else if (isum < ISUM_LO) begin
         integ_new   = ISUM_LO[INTEG_W-1:0];
         integ_clamp = 1'b1;
      end
   end

   // Sequencer next state: init frame first, then sample -> CALC -> LOAD -> XFER
   always_comb begin
      lstate_d  = lstate;
      spi_start = 1'b0;
      case (lstate)
         LS_IDLE: begin
            if (init_req) begin
               if (!spi_busy) begin
                  spi_start = 1'b1;
                  lstate_d  = LS_XFER;
               end
            end else if (ev_acc || (pending && !bus.HOLD)) begin
               lstate_d = LS_CALC;
            end
         end
         LS_CALC: lstate_d = LS_LOAD;
         LS_LOAD: begin
            if (!spi_busy) begin
               spi_start = 1'b1;
               lstate_d  = LS_XFER;
            end
         end
         LS_XFER: begin
            // A waiting sample goes straight from the frame tail into the next update
            if (spi_done)
               lstate_d = (ev_acc || (pending && !bus.HOLD)) ? LS_CALC : LS_IDLE;
         end
      endcase
   end

   // Sequencer state, RDY edge history and the init-frame request
   always_ff @(posedge CLK) begin
      if (CLR) begin
         lstate   <= LS_IDLE;
         rdy_q    <= 1'b0;
         init_req <= 1'b1;
      end else begin
         lstate <= lstate_d;
         rdy_q  <= bus.RDY;
         if (lstate == LS_IDLE)
            init_req <= 1'b0;
      end
   end

   // Sample capture and the newest-wins pending flag
   always_ff @(posedge CLK) begin
      if (CLR) begin
         samp    <= '0;
         pending <= 1'b0;
      end else begin
         if (ev_acc)
            samp <= bus.DIFF;
         if (bus.HOLD || go_calc)
            pending <= 1'b0;
         else if (ev_acc)
            pending <= 1'b1;
      end
   end

   // Loop filter state: updated only in CALC and frozen under HOLD
   always_ff @(posedge CLK) begin
      if (CLR) begin
         integ <= '0;
         sat   <= 1'b0;
         tune  <= DAC_W'(DAC_INIT);
      end else if (lstate == LS_CALC && !bus.HOLD) begin
         integ <= integ_new;
         sat   <= integ_clamp;
         tune  <= clamp_dac(tsum);
      end
   end

   dac_spi_tx #(
      .SCLK_DIV_P (SCLK_DIV)
   ) u_spi (
      .clk    (CLK),
      .rst    (CLR),
      .start  (spi_start),
      .word   (tune),
      .busy   (spi_busy),
      .done   (spi_done),
      .sclk   (bus.SCLK),
      .sync_n (bus.SYNC_N),
      .sdo    (bus.SDO)
   );

   assign bus.TUNE = tune;
   assign bus.SAT  = sat;
   assign bus.BUSY = (lstate != LS_IDLE);

`ifdef TUNE_LOCK_DET_EN
   localparam logic signed [ERR_W-1:0] TOL_P = ERR_W'(LOCK_TOL);
   localparam logic signed [ERR_W-1:0] TOL_N = -TOL_P;
   localparam logic [4:0]              LCNT  = 5'(LOCK_CNT);

   logic [4:0] lock_cnt;

   // Count consecutive in-window samples, saturating at the lock threshold
   always_ff @(posedge CLK) begin
      if (CLR || bus.HOLD) begin
         lock_cnt <= '0;
      end else if (lstate == LS_CALC) begin
         if (err <= TOL_P && err >= TOL_N) begin
            if (lock_cnt != LCNT)
               lock_cnt <= lock_cnt + 1'b1;
         end else begin
            lock_cnt <= '0;
         end
      end
   end

   assign bus.LOCKED = (lock_cnt == LCNT);
`else
   assign bus.LOCKED = 1'b0;
`endif

endmodule

// File: tb/tb_ocxo_tune_ctrl.sv
// Self-checking bench for ocxo_tune_ctrl: random and directed samples against a PI reference model.
// Latency: checks TUNE at N+1 and SYNC_N at N+2 after a sample edge, and the 133-cycle frame.
// Backpressure: exercises newest-wins pending, HOLD drop, and reset in the middle of a frame.
module tb_ocxo_tune_ctrl;

   localparam int IMAX = 8388607;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   ocxo_tune_ctrl_if bus();

   ocxo_tune_ctrl dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_integ = 0;
   int m_tune  = 32768;
   int m_sat   = 0;
   int m_lock  = 0;

   function automatic int floor_div(input int a, input int d);
      int q;
      q = a / d;
      if ((a % d != 0) && (a < 0))
         q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_integ = 0;
      m_tune  = 32768;
      m_sat   = 0;
      m_lock  = 0;
   endtask

   task automatic model_apply(input int diff);
      int err;
      int t;
      err     = diff - 32767;
      m_integ = m_integ + err;
      m_sat   = 0;
      if (m_integ > IMAX) begin
         m_integ = IMAX;
         m_sat   = 1;
      end else if (m_integ < -IMAX) begin
         m_integ = -IMAX;
         m_sat   = 1;
      end
      t = 32768 - floor_div(err, 4) - floor_div(m_integ, 64);
      if (t < 0)     t = 0;
      if (t > 65535) t = 65535;
      m_tune = t;
      if (err >= -8 && err <= 8)
         m_lock = (m_lock < 16) ? m_lock + 1 : 16;
      else
         m_lock = 0;
   endtask

   function automatic int exp_locked();
`ifdef TUNE_LOCK_DET_EN
      return (m_lock >= 16) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   // ---------------- DAC frame monitor ----------------
   int          nframes   = 0;
   int          mon_nb    = 0;
   logic [15:0] mon_sh    = '0;
   logic [15:0] last_word = '0;
   logic        prev_sync = 1'b1;
   logic        prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (prev_sync && !bus.SYNC_N) begin
         mon_nb = 0;
         mon_sh = '0;
      end
      if (!bus.SYNC_N && !prev_sclk && bus.SCLK) begin
         mon_sh = {mon_sh[14:0], bus.SDO};
         mon_nb++;
      end
      if (!prev_sync && bus.SYNC_N && mon_nb == 16) begin
         last_word = mon_sh;
         nframes++;
      end
      prev_sync = bus.SYNC_N;
      prev_sclk = bus.SCLK;
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_rdy(input int diff);
      @(negedge clk);
      bus.DIFF = 16'(diff);
      bus.RDY  = 1'b1;
      @(negedge clk);
      bus.RDY  = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.BUSY && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000)
         chk("idle_timeout", 32'(bus.BUSY), 0);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_tune"},   32'(bus.TUNE),   32'(m_tune));
      chk({tag, "_sat"},    32'(bus.SAT),    32'(m_sat));
      chk({tag, "_locked"}, 32'(bus.LOCKED), 32'(exp_locked()));
   endtask

   task automatic send_sample(input int diff, input string tag);
      int f0;
      int n;
      f0 = nframes;
      pulse_rdy(diff);
      model_apply(diff);
      wait_idle(n);
      check_state(tag);
      chk({tag, "_frames"}, 32'(nframes), 32'(f0 + 1));
      chk({tag, "_word"},   32'(last_word), 32'(m_tune));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      int f0;
      int d;
      bus.DIFF = '0;
      bus.RDY  = 1'b0;
      bus.HOLD = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_tune",   32'(bus.TUNE),   32'h8000);
      chk("rst_busy",   32'(bus.BUSY),   0);
      chk("rst_sat",    32'(bus.SAT),    0);
      chk("rst_sclk",   32'(bus.SCLK),   0);
      chk("rst_sync_n", 32'(bus.SYNC_N), 1);
      chk("rst_sdo",    32'(bus.SDO),    0);
      chk("rst_locked", 32'(bus.LOCKED), 0);

      // Init frame after reset release
      clr = 1'b0;
      @(negedge clk);
      wait_idle(n);
      chk("init_busy_len", 32'(n), 133);
      chk("init_frames",   32'(nframes), 1);
      chk("init_word",     32'(last_word), 32'h8000);
      model_reset();
      check_state("init");

      send_sample(32767, "zero_err");

      // Directed err=+400 with latency checks
      f0 = nframes;
      pulse_rdy(33167);
      chk("lat_busy_n",  32'(bus.BUSY),   1);
      chk("lat_tune_n",  32'(bus.TUNE),   32'h8000);
      @(negedge clk);
      chk("lat_tune_n1", 32'(bus.TUNE),   32'h7F96);
      chk("lat_sync_n1", 32'(bus.SYNC_N), 1);
      @(negedge clk);
      chk("lat_sync_n2", 32'(bus.SYNC_N), 0);
      model_apply(33167);
      wait_idle(n);
      check_state("err400");
      chk("err400_frames", 32'(nframes), 32'(f0 + 1));
      chk("err400_word",   32'(last_word), 32'h7F96);

      // Random samples, mostly near centre with occasional full-scale ones
      for (int i = 0; i < 20; i++) begin
         if (i % 5 == 4)
            d = int'($urandom_range(65535, 0));
         else
            d = int'($urandom_range(34767, 30767));
         send_sample(d, "rand");
      end

      // Three RDY rises during one frame: exactly one extra frame with the third
      f0 = nframes;
      d  = int'($urandom_range(33767, 31767));
      pulse_rdy(d);
      model_apply(d);
      repeat (10) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         d = int'($urandom_range(33767, 31767));
         pulse_rdy(d);
         @(negedge clk);
      end
      model_apply(d);
      wait_idle(n);
      chk("triple_frames", 32'(nframes), 32'(f0 + 2));
      chk("triple_word",   32'(last_word), 32'(m_tune));
      check_state("triple");

      // HOLD rising mid-frame drops the pending sample
      f0 = nframes;
      d  = int'($urandom_range(33767, 31767));
      pulse_rdy(d);
      model_apply(d);
      repeat (10) @(negedge clk);
      pulse_rdy(40000);
      @(negedge clk);
      bus.HOLD = 1'b1;
      m_lock   = 0;
      wait_idle(n);
      repeat (5) @(negedge clk);
      chk("holdmid_frames", 32'(nframes), 32'(f0 + 1));
      check_state("holdmid");

      // Samples under HOLD are ignored entirely
      for (int k = 0; k < 3; k++) begin
         pulse_rdy(int'($urandom_range(65535, 0)));
         repeat (3) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk("hold_frames", 32'(nframes), 32'(f0 + 1));
      chk("hold_busy",   32'(bus.BUSY), 0);
      check_state("hold");
      bus.HOLD = 1'b0;
      @(negedge clk);
      send_sample(33167, "resume");

      // Drive the integrator into its negative clamp
      for (int i = 0; i < 275; i++)
         send_sample(0, "sat_run");
      chk("sat_final",  32'(bus.SAT),  1);
      chk("sat_tune",   32'(bus.TUNE), 32'hFFFF);
      send_sample(65535, "sat_recover");

      // Reset in the middle of a frame
      pulse_rdy(40000);
      repeat (66) @(negedge clk);
      chk("clrmid_active", 32'(bus.SYNC_N), 0);
      f0  = nframes;
      clr = 1'b1;
      @(negedge clk);
      chk("clrmid_sync_n", 32'(bus.SYNC_N), 1);
      chk("clrmid_sclk",   32'(bus.SCLK),   0);
      chk("clrmid_busy",   32'(bus.BUSY),   0);
      chk("clrmid_tune",   32'(bus.TUNE),   32'h8000);
      chk("clrmid_sat",    32'(bus.SAT),    0);
      clr = 1'b0;
      @(negedge clk);
      wait_idle(n);
      chk("reinit_busy_len", 32'(n), 133);
      chk("reinit_frames",   32'(nframes), 32'(f0 + 1));
      chk("reinit_word",     32'(last_word), 32'h8000);
      model_reset();
      send_sample(33167, "after_clr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ocxo_tune_ctrl.md
Name: ocxo_tune_ctrl

Overview:
Consumer end of the PPS frequency-difference interface. Takes each offset-binary DIFF sample (CENTER means zero error) and qualifies it with the RDY level. Runs a PI loop filter on the sample and drives the 16-bit OCXO tuning DAC over a 3-wire SPI link. Sits between the PPS counter and the DAC pins, closing the GPSDO loop.

Parameters:
CENTER, 32767, DIFF code that means zero frequency error
KP_SHIFT, 2, proportional gain as an arithmetic right shift of the error
KI_SHIFT, 6, integral gain as an arithmetic right shift of the integrator
DAC_INIT, 32768, tuning word after reset; PI output is offset from this
SCLK_DIV, 4, CLK cycles per SCLK half-period (must be >= 1)
LOCK_TOL, 8, lock window: |err| <= LOCK_TOL counts (optional feature only)
LOCK_CNT, 16, consecutive in-window samples needed to declare lock (optional feature only)

Ports:
CLK  in  1  system clock, the single clock domain
CLR  in  1  synchronous active-high reset
DIFF  in  16  offset-binary frequency difference, valid when RDY rises
RDY  in  1  sample-ready level, already synchronous to CLK; rising edge = new sample
HOLD  in  1  holdover: ignore samples, freeze integrator and TUNE
TUNE  out  16  current tuning word (last value sent or being sent)
BUSY  out  1  high from sample accept until frame tail done
SAT  out  1  integrator clamped on the last update
SCLK  out  1  DAC serial clock, idles low
SYNC_N  out  1  DAC frame select, active low
SDO  out  1  DAC serial data, MSB first
LOCKED  out  1  loop lock indicator

Behaviour:
- Reset values while CLR=1: TUNE=DAC_INIT, integ=0, SAT=0, BUSY=0, SCLK=0, SYNC_N=1, SDO=0, LOCKED=0, pending=0, rdy_q=0.
- After CLR falls, the block sends one frame with TUNE=DAC_INIT before accepting samples. This puts the DAC in a known state.
- Sample event: RDY=1 and rdy_q=0 at a CLK edge. rdy_q is RDY registered. Events are ignored while HOLD=1.
- Arithmetic:
  - err = DIFF - CENTER, signed 17-bit.
  - integ is signed 24-bit: integ += err, saturating at ±(2^23-1). SAT=1 whenever a clamp occurred.
  - p = err >>> KP_SHIFT; i = integ(new) >>> KI_SHIFT.
  - sum = DAC_INIT - p - i, signed 26-bit, clamped to 0..65535.
  - Positive err (oscillator fast) lowers TUNE.
- FSM states:
  - IDLE: wait for an event or pending sample.
  - CALC (1 cycle): update integ, SAT and TUNE.
  - LOAD (1 cycle): SYNC_N=0, SDO=TUNE[15].
  - SHIFT: 16 bits. Each bit is SCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles; SDO changes only on the SCLK fall. The DAC samples on the SCLK rise.
  - TAIL: SYNC_N=1 and SCLK=0 for SCLK_DIV cycles, then return to IDLE.
- Latency: event at edge N gives TUNE updated at edge N+1 and SYNC_N low at edge N+2. Frame length = 32*SCLK_DIV + 1 + SCLK_DIV cycles.
- BUSY is high in CALC, LOAD, SHIFT and TAIL.
- Event while BUSY: DIFF is captured into a one-deep pending register.
  - A second event overwrites the pending sample (newest wins).
  - The pending sample is processed directly from TAIL→CALC.
- HOLD rising mid-frame: the current frame completes and pending is cleared. HOLD falling: resume with integ unchanged.
- CLR mid-frame: immediate reset values (SYNC_N=1 on the next edge), then the init frame is resent.

Optional Feature:
TUNE_LOCK_DET_EN
- Defined: a 5-bit counter increments on each processed sample with |err| <= LOCK_TOL. It resets to 0 otherwise, and on HOLD.
- LOCKED=1 once the counter reaches LOCK_CNT. The counter saturates there.
- LOCKED drops on the first out-of-window sample.
- Undefined: LOCKED tied to 0 and no counter logic is built.

Decomposition:
- Shared package gps_pkg: CENTER and DAC_INIT constants, FSM state enum, and the err/integ width localparams, shared with the PPS counter.
- Natural sub-module: dac_spi_tx. It holds the 16-bit shifter, SCLK divider and SYNC_N framing, with a start/busy handshake. The loop filter and FSM stay in the top.

Test Plan:
- CLR 1→0 → SYNC_N low once and SDO shifts 0x8000; TUNE=0x8000 and BUSY falls after 32*4+1+4=133 cycles.
- After init, DIFF=32767 with a RDY rise → err=0, TUNE stays 0x8000 and one frame carries 0x8000.
- DIFF=33167 (err=+400), KP=2, KI=6, from integ=0 → integ=400, TUNE=32768-100-6=0x7F96; the SPI-captured word matches.
- Repeated DIFF=0 samples → TUNE clamps at 0xFFFF and SAT eventually =1; no wrap on integ or TUNE.
- Three RDY rises during one frame → exactly one extra frame, carrying the third sample; HOLD=1 with RDY rises → no frames, TUNE unchanged.
- CLR asserted at bit 7 of a frame → SYNC_N=1 next edge, integ=0, init frame 0x8000 resent.
